opendap_swd_link_ctrl: RTL and testbench
========================================

// Module: opendap_swd_link_ctrl
// PURPOSE
//  Target-side SWD link-state controller. Consumes dormant-monitor events (exit_dormant,
//  enter_dormant, line_reset) and per-packet events from the SWD serial engine. Tracks the
//  ADIv5 link state: Dormant / Reset / Active / Lockout / Deselected. Tells the serial engine,
//  per header, whether to respond. Sits between the dormant monitor and the serial engine.
// PARAMETERS
//  RESET_DORMANT  1  1: reset state is DORMANT; 0: reset state is LOCKOUT (line reset required)
//  MULTIDROP      1  1: TARGETSEL is honoured in the Reset state; 0: TARGETSEL is treated as any other header
//  W_ERRCNT       8  Width of the saturating lockout-entry counter
// PORTS
//  swclk            in   1         SWD clock; all state changes on posedge
//  rst              in   1         Asynchronous, active-high reset
//  exit_dormant     in   1         Pulse: dormant-to-SWD select sequence completed
//  enter_dormant    in   1         Pulse: SWD-to-dormant select sequence completed
//  line_reset       in   1         Level: at least 50 consecutive ones seen
//  hdr_valid        in   1         Pulse: 8-bit request header received
//  hdr_parity_ok    in   1         Header parity correct (qualified by hdr_valid)
//  hdr_apndp        in   1         Header APnDP bit
//  hdr_rnw          in   1         Header RnW bit
//  hdr_addr         in   2         Header A[3:2]
//  pkt_done         in   1         Pulse: accepted packet finished (ack plus data phase)
//  pkt_ack          in   3         ACK driven for the finished packet (OK=3'b001)
//  tsel_match       in   1         TARGETSEL write data matched TARGETID (qualified by pkt_done)
//  err_clr          in   1         Clear lockout_cnt
//  hdr_accept       out  1         Combinational, same cycle as hdr_valid: engine runs this packet
//  hdr_noack        out  1         Combinational: accepted packet drives no ACK (TARGETSEL)
//  pkt_abort        out  1         Pulse: in-flight packet aborted by line reset or dormant entry
//  link_state       out  3         Current state encoding
//  dormant          out  1         link_state == DORMANT; used for clock/power gating
//  lockout_cnt      out  W_ERRCNT  Saturating count of entries into LOCKOUT
// BEHAVIOUR
//  States: DORMANT=0, LRESET=1, ACTIVE=2, LOCKOUT=3, DESEL=4. Any other encoding -> LOCKOUT next cycle.
//  Reset values: link_state = RESET_DORMANT ? DORMANT : LOCKOUT; busy=0; lockout_cnt=0.
//    All pulse outputs and hdr_accept/hdr_noack are 0 during reset.
//  Event priority, highest first: enter_dormant > exit_dormant > line_reset > packet events.
//  Transitions:
//   - DORMANT: exit_dormant -> LOCKOUT (line reset still required). All other inputs ignored;
//     hdr_accept = 0.
//   - Any non-DORMANT state: enter_dormant -> DORMANT; line_reset -> LRESET (held while level high).
//   - LRESET, hdr_valid:
//     - Parity ok and DP read of addr 0 (DPIDR): accept. On pkt_done, ack OK -> ACTIVE; otherwise stay.
//     - MULTIDROP, parity ok and DP write of addr 3 (TARGETSEL): accept with hdr_noack=1.
//       On pkt_done: tsel_match -> stay LRESET; otherwise -> DESEL.
//     - Any other header, or a parity failure: not accepted; stay in LRESET.
//   - ACTIVE, hdr_valid:
//     - Parity fail -> LOCKOUT, not accepted.
//     - TARGETSEL -> LOCKOUT, not accepted.
//     - Otherwise accept.
//     - pkt_ack is informational only; WAIT and FAULT keep ACTIVE.
//   - DESEL and LOCKOUT: hdr_accept = 0. Leave only via line_reset or enter_dormant.
//  Busy flag: set on an accepted header, cleared on pkt_done.
//   - hdr_valid while busy is a protocol violation: ignore it, no state change.
//   - line_reset or enter_dormant while busy: pkt_abort=1 for exactly one cycle, busy cleared,
//     and the pending pkt_done is not waited for.
//   - pkt_done when not busy: ignored.
//  lockout_cnt: +1 on each transition into LOCKOUT from any other state (reset value excluded).
//   - Saturates at all-ones.
//   - err_clr wins over a simultaneous increment.
//  Latency: state updates on the swclk edge after the triggering event. hdr_accept/hdr_noack
//    have zero latency (decoded from the current state and header).
// STRUCTURE
//  Shared include opendap_swd_defs.vh holds:
//   - Link state encodings.
//   - ACK codes: OK=001, WAIT=010, FAULT=100.
//   - DP address constants: DPIDR=0, TARGETSEL=3.
//  Shared with the serial engine and the DP.
//  Single module, no sub-modules. The saturating counter is inline.
// TESTING
//  - rst, RESET_DORMANT=1; drive exit_dormant -> LOCKOUT; then line_reset -> LRESET.
//    Then DPIDR read + ack 001 -> link_state=2, lockout_cnt=1.
//  - ACTIVE; header with parity_ok=0 -> hdr_accept=0 same cycle, link_state=3, lockout_cnt=2.
//    Further headers get hdr_accept=0.
//  - LRESET, MULTIDROP=1; TARGETSEL write -> hdr_accept=1, hdr_noack=1.
//    pkt_done with tsel_match=0 -> DESEL; a DPIDR read is then ignored; line_reset -> LRESET.
//  - ACTIVE, accepted AP read in flight; line_reset -> pkt_abort for 1 cycle, LRESET.
//    The late pkt_done is ignored.
//  - Same cycle: enter_dormant=1 and line_reset=1 -> DORMANT, dormant=1.
//    Then a hdr_valid -> hdr_accept=0.
//  - Force lockout_cnt to 255 (W_ERRCNT=8); another lockout -> stays 255.
//    err_clr concurrent with an increment -> 0.

Source files
------------

// File: rtl/opendap_swd_link_ctrl_pkg.sv
// Shared SWD link definitions: link-state encodings, ACK codes, DP register addresses
// and the header decode helpers used by the link controller, serial engine and DP.
package opendap_swd_link_ctrl_pkg;

    typedef enum logic [2:0] {
        LS_DORMANT = 3'd0,
        LS_LRESET  = 3'd1,
        LS_ACTIVE  = 3'd2,
        LS_LOCKOUT = 3'd3,
        LS_DESEL   = 3'd4
    } link_state_e;

    localparam logic [2:0] ACK_OK    = 3'b001;
    localparam logic [2:0] ACK_WAIT  = 3'b010;
    localparam logic [2:0] ACK_FAULT = 3'b100;

    localparam logic [1:0] DP_ADDR_DPIDR     = 2'd0;
    localparam logic [1:0] DP_ADDR_TARGETSEL = 2'd3;

    function automatic logic is_dpidr_read(input logic apndp, input logic rnw,
                                           input logic [1:0] addr);
        return !apndp && rnw && (addr == DP_ADDR_DPIDR);
    endfunction

    function automatic logic is_targetsel_write(input logic apndp, input logic rnw,
                                                input logic [1:0] addr);
        return !apndp && !rnw && (addr == DP_ADDR_TARGETSEL);
    endfunction

endpackage

// File: rtl/opendap_swd_link_ctrl_if.sv
// Event and status bundle between the dormant monitor / serial engine (master side)
// and the SWD link-state controller (slave side).
interface opendap_swd_link_ctrl_if #(
    parameter int W_ERRCNT = 8
) ();

    logic                exit_dormant;
    logic                enter_dormant;
    logic                line_reset;
    logic                hdr_valid;
    logic                hdr_parity_ok;
    logic                hdr_apndp;
    logic                hdr_rnw;
    logic [1:0]          hdr_addr;
    logic                pkt_done;
    logic [2:0]          pkt_ack;
    logic                tsel_match;
    logic                err_clr;
    logic                hdr_accept;
    logic                hdr_noack;
    logic                pkt_abort;
    logic [2:0]          link_state;
    logic                dormant;
    logic [W_ERRCNT-1:0] lockout_cnt;

    modport master (
        output exit_dormant, enter_dormant, line_reset,
        output hdr_valid, hdr_parity_ok, hdr_apndp, hdr_rnw, hdr_addr,
        output pkt_done, pkt_ack, tsel_match, err_clr,
        input  hdr_accept, hdr_noack, pkt_abort, link_state, dormant, lockout_cnt
    );

    modport slave (
        input  exit_dormant, enter_dormant, line_reset,
        input  hdr_valid, hdr_parity_ok, hdr_apndp, hdr_rnw, hdr_addr,
        input  pkt_done, pkt_ack, tsel_match, err_clr,
        output hdr_accept, hdr_noack, pkt_abort, link_state, dormant, lockout_cnt
    );

endinterface

// File: rtl/opendap_swd_link_ctrl.sv
// Target-side SWD link-state controller: tracks Dormant/Reset/Active/Lockout/Deselected
// and tells the serial engine, per request header, whether to run the packet.
module opendap_swd_link_ctrl
    import opendap_swd_link_ctrl_pkg::*;
#(
    parameter bit RESET_DORMANT = 1'b1,
    parameter bit MULTIDROP     = 1'b1,
    parameter int W_ERRCNT      = 8
) (
    input logic                    swclk,
    input logic                    rst,
    opendap_swd_link_ctrl_if.slave link
);

    link_state_e         state_q, state_d;
    logic                busy_q, busy_d;
    logic                pend_tsel_q, pend_tsel_d;
    logic                abort_q, abort_d;
    logic [W_ERRCNT-1:0] cnt_q, cnt_d;

    logic hdr_live;
    logic dpidr_rd;
    logic tsel_wr;
    logic accept;
    logic noack;
    logic enter_lockout;

    // Header decode is zero-latency; link events outrank a header arriving in the same cycle.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        hdr_live = link.hdr_valid && !busy_q && !link.enter_dormant && !link.line_reset;
        dpidr_rd = link.hdr_parity_ok && is_dpidr_read(link.hdr_apndp, link.hdr_rnw, link.hdr_addr);
        tsel_wr  = MULTIDROP && is_targetsel_write(link.hdr_apndp, link.hdr_rnw, link.hdr_addr);
        accept   = 1'b0;
        noack    = 1'b0;
        if (!rst && hdr_live) begin
            case (state_q)
                LS_LRESET: begin
                    if (dpidr_rd) begin
                        accept = 1'b1;
                    end else if (tsel_wr && link.hdr_parity_ok) begin
                        accept = 1'b1;
                        noack  = 1'b1;
                    end
                end
                LS_ACTIVE: accept = link.hdr_parity_ok && !tsel_wr;
                default:   accept = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        pend_tsel_d = pend_tsel_q;
        abort_d     = 1'b0;
        case (state_q)
            LS_DORMANT: begin
                busy_d = 1'b0;
                if (link.exit_dormant) state_d = LS_LOCKOUT;
            end
            LS_LRESET, LS_ACTIVE, LS_LOCKOUT, LS_DESEL: begin
                if (link.enter_dormant || link.line_reset) begin
                    state_d = link.enter_dormant ? LS_DORMANT : LS_LRESET;
                    abort_d = busy_q;
                    busy_d  = 1'b0;
                end else if (link.hdr_valid && !busy_q) begin
                    if (accept) begin
                        busy_d      = 1'b1;
                        pend_tsel_d = noack;
                    end else if (state_q == LS_ACTIVE) begin
                        state_d = LS_LOCKOUT;
                    end
                end else if (link.pkt_done && busy_q) begin
                    busy_d = 1'b0;
                    if (state_q == LS_LRESET) begin
                        if (pend_tsel_q) begin
                            if (!link.tsel_match) state_d = LS_DESEL;
                        end else if (link.pkt_ack == ACK_OK) begin
                            state_d = LS_ACTIVE;
                        end
                    end
                end
            end
            default: begin
                state_d = LS_LOCKOUT;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Saturating lockout-entry count; a clear beats a same-cycle increment.
    always_comb begin
        enter_lockout = (state_d == LS_LOCKOUT) && (state_q != LS_LOCKOUT);
        cnt_d         = cnt_q;
        if (link.err_clr) begin
            cnt_d = '0;
        end else if (enter_lockout && (cnt_q != {W_ERRCNT{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge swclk or posedge rst) begin
        if (rst) begin
            state_q     <= RESET_DORMANT ? LS_DORMANT : LS_LOCKOUT;
            busy_q      <= 1'b0;
            pend_tsel_q <= 1'b0;
            abort_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            pend_tsel_q <= pend_tsel_d;
            abort_q     <= abort_d;
            cnt_q       <= cnt_d;
        end
    end

    assign link.hdr_accept  = accept;
    assign link.hdr_noack   = noack;
    assign link.pkt_abort   = abort_q;
    assign link.link_state  = state_q;
    assign link.dormant     = (state_q == LS_DORMANT);
    assign link.lockout_cnt = cnt_q;

endmodule

// File: tb/tb_opendap_swd_link_ctrl.sv
// Scoreboard bench for opendap_swd_link_ctrl: a driver pushes expected responses from a
// rule-level link model, and a negedge monitor pops and compares them against the DUT.
module tb_opendap_swd_link_ctrl;
    import opendap_swd_link_ctrl_pkg::*;

    localparam bit RESET_DORMANT = 1'b1;
    localparam bit MULTIDROP     = 1'b1;
    localparam int W_ERRCNT      = 8;
    localparam int CNT_MAX       = (1 << W_ERRCNT) - 1;
    localparam int S_DOR = 0, S_LRS = 1, S_ACT = 2, S_LCK = 3, S_DSL = 4;

    logic swclk = 1'b0;
    logic rst   = 1'b1;
    always #5 swclk = ~swclk;

    opendap_swd_link_ctrl_if #(.W_ERRCNT(W_ERRCNT)) link ();

    opendap_swd_link_ctrl #(
        .RESET_DORMANT(RESET_DORMANT),
        .MULTIDROP    (MULTIDROP),
        .W_ERRCNT     (W_ERRCNT)
    ) dut (
        .swclk(swclk),
        .rst  (rst),
        .link (link)
    );

    typedef struct {
        bit       rst, exit_d, enter_d, lreset;
        bit       hv, par, apndp, rnw;
        bit [1:0] addr;
        bit       pdone;
        bit [2:0] ack;
        bit       tmatch, eclr;
    } stim_t;

    typedef struct {
        bit acc, noack, dorm, abort;
        int state;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    int m_state;
    bit m_busy, m_pend_tsel, m_abort;
    int m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge swclk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("hdr_accept",  32'(link.hdr_accept),  32'(mon_e.acc));
            check("hdr_noack",   32'(link.hdr_noack),   32'(mon_e.noack));
            check("link_state",  32'(link.link_state),  mon_e.state);
            check("dormant",     32'(link.dormant),     32'(mon_e.dorm));
            check("pkt_abort",   32'(link.pkt_abort),   32'(mon_e.abort));
            check("lockout_cnt", 32'(link.lockout_cnt), mon_e.cnt);
        end
    end

    function automatic void model_reset();
        m_state     = RESET_DORMANT ? S_DOR : S_LCK;
        m_busy      = 1'b0;
        m_pend_tsel = 1'b0;
        m_abort     = 1'b0;
        m_cnt       = 0;
    endfunction

    // Which headers the link lets through: DPIDR read or TARGETSEL after a line reset, anything clean when active.
    function automatic void model_hdr(input stim_t s, output bit acc, output bit noack);
        bit dp_rd0, tsel;
        acc    = 1'b0;
        noack  = 1'b0;
        dp_rd0 = s.par && !s.apndp && s.rnw && (s.addr == 2'd0);
        tsel   = MULTIDROP && !s.apndp && !s.rnw && (s.addr == 2'd3);
        if (s.rst || !s.hv || m_busy || s.enter_d || s.lreset) return;
        if (m_state == S_LRS) begin
            if (dp_rd0) acc = 1'b1;
            else if (tsel && s.par) begin
                acc   = 1'b1;
                noack = 1'b1;
            end
        end else if (m_state == S_ACT) begin
            acc = s.par && !tsel;
        end
    endfunction

    function automatic void model_edge(input stim_t s, input bit acc, input bit noack);
        int old;
        old     = m_state;
        m_abort = 1'b0;
        if (m_state == S_DOR) begin
            if (s.exit_d) m_state = S_LCK;
        end else if (s.enter_d || s.lreset) begin
            m_abort = m_busy;
            m_busy  = 1'b0;
            m_state = s.enter_d ? S_DOR : S_LRS;
        end else if (s.hv && !m_busy) begin
            if (acc) begin
                m_busy      = 1'b1;
                m_pend_tsel = noack;
            end else if (m_state == S_ACT) begin
                m_state = S_LCK;
            end
        end else if (s.pdone && m_busy) begin
            m_busy = 1'b0;
            if (m_state == S_LRS) begin
                if (m_pend_tsel) begin
                    if (!s.tmatch) m_state = S_DSL;
                end else if (s.ack == ACK_OK) begin
                    m_state = S_ACT;
                end
            end
        end
        if (s.eclr) m_cnt = 0;
        else if (m_state == S_LCK && old != S_LCK && m_cnt < CNT_MAX) m_cnt++;
    endfunction

    task automatic drive(input stim_t s);
        exp_t e;
        bit   acc, noack;
        @(posedge swclk);
        #1;
        rst                = s.rst;
        link.exit_dormant  = s.exit_d;
        link.enter_dormant = s.enter_d;
        link.line_reset    = s.lreset;
        link.hdr_valid     = s.hv;
        link.hdr_parity_ok = s.par;
        link.hdr_apndp     = s.apndp;
        link.hdr_rnw       = s.rnw;
        link.hdr_addr      = s.addr;
        link.pkt_done      = s.pdone;
        link.pkt_ack       = s.ack;
        link.tsel_match    = s.tmatch;
        link.err_clr       = s.eclr;
        if (s.rst) model_reset();
        model_hdr(s, acc, noack);
        e.acc   = acc;
        e.noack = noack;
        e.state = m_state;
        e.dorm  = (m_state == S_DOR);
        e.abort = m_abort;
        e.cnt   = m_cnt;
        exp_q.push_back(e);
        if (s.rst) model_reset();
        else model_edge(s, acc, noack);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic stim_t ev(input bit ex, input bit en, input bit lr, input bit ec);
        stim_t s;
        s         = idle();
        s.exit_d  = ex;
        s.enter_d = en;
        s.lreset  = lr;
        s.eclr    = ec;
        return s;
    endfunction

    function automatic stim_t hdr(input bit par, input bit apndp, input bit rnw, input bit [1:0] addr);
        stim_t s;
        s       = idle();
        s.hv    = 1'b1;
        s.par   = par;
        s.apndp = apndp;
        s.rnw   = rnw;
        s.addr  = addr;
        return s;
    endfunction

    function automatic stim_t done(input bit [2:0] ack, input bit tmatch);
        stim_t s;
        s        = idle();
        s.pdone  = 1'b1;
        s.ack    = ack;
        s.tmatch = tmatch;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t    s;
        int       pick;
        bit [2:0] acks [5];
        acks = '{ACK_OK, ACK_OK, ACK_WAIT, ACK_FAULT, 3'b000};
        pick = $urandom_range(0, 99);
        if (pick < 3)       s = ev(1, 0, 0, 0);
        else if (pick < 6)  s = ev(0, 1, 0, 0);
        else if (pick < 12) s = ev(0, 0, 1, 0);
        else if (pick < 55) begin
            case ($urandom_range(0, 3))
                0:       s = hdr(1'b1, 1'b0, 1'b1, 2'd0);
                1:       s = hdr(1'b1, 1'b0, 1'b0, 2'd3);
                default: s = hdr(1'b1, 1'($urandom), 1'($urandom), 2'($urandom));
            endcase
            s.par = ($urandom_range(0, 7) != 0);
        end else if (pick < 80) begin
            s = done(acks[$urandom_range(0, 4)], 1'($urandom));
        end else begin
            s = idle();
        end
        s.eclr = ($urandom_range(0, 31) == 0);
        s.rst  = ($urandom_range(0, 499) == 0);
        return s;
    endfunction

    initial begin
        stim_t s;
        link.exit_dormant = 0; link.enter_dormant = 0; link.line_reset = 0;
        link.hdr_valid = 0; link.hdr_parity_ok = 0; link.hdr_apndp = 0; link.hdr_rnw = 0;
        link.hdr_addr = 0; link.pkt_done = 0; link.pkt_ack = 0; link.tsel_match = 0;
        link.err_clr = 0;
        model_reset();

        s = idle();
        s.rst = 1'b1;
        drive(s);
        drive(s);

        // Bring-up: lockout, line reset, DPIDR read with OK ack.
        drive(ev(1, 0, 0, 0));
        drive(ev(0, 0, 1, 0));
        drive(hdr(1, 0, 1, 2'd0));
        drive(idle());
        drive(done(ACK_OK, 0));
        drive(idle());

        drive(hdr(0, 0, 1, 2'd0));
        drive(hdr(1, 0, 1, 2'd0));

        // TARGETSEL mismatch deselects; only a line reset recovers.
        drive(ev(0, 0, 1, 0));
        drive(hdr(1, 0, 0, 2'd3));
        drive(done(ACK_OK, 0));
        drive(hdr(1, 0, 1, 2'd0));
        drive(ev(0, 0, 1, 0));

        // Abort of an in-flight AP read, then a stale pkt_done.
        drive(hdr(1, 0, 1, 2'd0));
        drive(done(ACK_OK, 0));
        drive(hdr(1, 1, 1, 2'd1));
        drive(ev(0, 0, 1, 0));
        drive(idle());
        drive(done(ACK_OK, 0));
        drive(idle());

        drive(ev(0, 1, 1, 0));
        drive(hdr(1, 0, 1, 2'd0));
        drive(idle());

        // Saturate the lockout counter, then clear it against a concurrent increment.
        drive(ev(1, 0, 0, 0));
        while (m_cnt < CNT_MAX) begin
            drive(ev(0, 1, 0, 0));
            drive(ev(1, 0, 0, 0));
        end
        drive(ev(0, 1, 0, 0));
        drive(ev(1, 0, 0, 0));
        drive(idle());
        drive(ev(0, 1, 0, 0));
        drive(ev(1, 0, 0, 1));
        drive(idle());

        for (int i = 0; i < 4000; i++) drive(rand_stim());
        drive(idle());

        repeat (2) @(negedge swclk);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
